regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file for the ID/WB stages, with per-register pending-write scoreboard.
//  NUM_RD read ports (ID), NUM_WR write-back ports (MEM/WB), one issue port (ID marks a destination pending).
//  Read ports report per-register busy so ID can stall on RAW hazards. Register 0 is hardwired to zero.
// PARAMETERS
//  DATA_W  32  register width
//  ADDR_W  5   address width; depth = 2**ADDR_W
//  NUM_RD  2   read ports (>=1)
//  NUM_WR  1   write-back ports (1..4)
//  PEND_W  2   pending-write counter width per register; max outstanding = 2**PEND_W-1
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-low reset (`RstEnable` = 1'b0)
//  wb_we      in   NUM_WR          per-port write enable (`WriteEnable`)
//  wb_addr    in   NUM_WR*ADDR_W   packed write addresses, port i at [i*ADDR_W +: ADDR_W]
//  wb_data    in   NUM_WR*DATA_W   packed write data
//  rd_re      in   NUM_RD          per-port read enable (`ReadEnable`)
//  rd_addr    in   NUM_RD*ADDR_W   packed read addresses
//  rd_data    out  NUM_RD*DATA_W   packed read data (combinational)
//  rd_busy    out  NUM_RD          1 = register has an uncommitted pending write
//  iss_valid  in   1               ID issues an instruction writing iss_addr
//  iss_addr   in   ADDR_W          destination being marked pending
//  iss_ready  out  1               issue accepted this cycle when iss_valid & iss_ready
//  sb_err     out  1               sticky: write-back to a register with zero pending count
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all regs = 0, all counters = 0, sb_err = 0.
//    Outputs during reset: rd_data = 0, rd_busy = 0, iss_ready = 0.
//  - Write: at posedge, each port with wb_we=1 and wb_addr!=0 writes regs[wb_addr]. Writes to addr 0 are discarded.
//    Two ports with the same address: the higher port index wins the data.
//  - Read: rd_re=0 -> rd_data=0, rd_busy=0 (no latching). addr 0 -> data 0, busy 0.
//    Otherwise data = regs[addr], busy = (cnt[addr]!=0); bypass per CONFIGURATION.
//  - Counter per register: +1 on an accepted issue, -k for the k write ports hitting it (we=1) in the same cycle.
//    Update is net, in a single cycle. Issue to addr 0 is accepted and ignored (no count).
//  - iss_ready = rst deasserted & cnt[iss_addr] != 2**PEND_W-1. It does not account for same-cycle decrements.
//  - Underflow: a write-back when the net count would drop below 0 -> data still written, count clamps to 0,
//    and sb_err is set (held until reset).
//  - Issue and write-back to the same reg in the same cycle: net 0; busy stays set if other writes are pending.
//  - Reset mid-operation: all pending counts are discarded. There is no replay.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read whose address matches an active write port returns that port's wb_data
//    (highest matching port). rd_busy excludes the write count retired this cycle:
//    busy = (cnt[addr] - hits) != 0.
//  Not defined: reads return stored regs only, and busy = cnt[addr]!=0. A written value and busy clear
//    become visible one cycle after the write edge.
// STRUCTURE
//  - defines.v: `RstEnable, `WriteEnable, `ReadEnable, `ZeroWord, `REGFILE_BYPASS_EN (commented default on).
//  - Sub-module regfile_scoreboard: counter array, issue/retire arithmetic, iss_ready, sb_err, busy lookup.
//  - The top module holds the data array, write-port priority, read muxes and bypass.
// TESTING (default params, bypass on unless noted)
//  1. Reset, then read r1..r31 -> all 0, busy 0, sb_err 0. Write r0=0xFFFF_FFFF -> r0 reads 0.
//  2. Write r5=0x1234_5678 on port 0 and read r5 in the same cycle -> 0x1234_5678.
//     Bypass off -> old value 0, then 0x1234_5678 next cycle.
//  3. Issue r7 three times -> busy=1, iss_ready=0 for r7 on the 4th attempt. Three write-backs -> busy clears on the last.
//  4. NUM_WR=2: both ports write r9 (0xA, 0xB) after 2 issues -> r9=0xB, count 0, busy 0.
//  5. Write-back to r3 with count 0 -> r3 updated, sb_err=1 and stays 1. Reset -> sb_err=0.
//  6. Issue r4 and write-back r4 in the same cycle with count 1 -> count stays 1, busy 1.
//     Assert rst mid-stream -> all counts 0, rd_data 0 while in reset.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file and its pending-write scoreboard.
package regfile_mp_sb_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending-write counters: issue/retire arithmetic, iss_ready, sticky sb_err and busy lookup.
// REGFILE_BYPASS_EN: busy excludes the write-backs retiring in the current cycle.
module regfile_mp_sb_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wb_we,
    input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
    input  logic [NUM_RD-1:0]        rd_re,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     sb_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HIT_W = $clog2(NUM_WR + 1);
    localparam int SUM_W = ((PEND_W > HIT_W) ? PEND_W : HIT_W) + 1;

    logic [PEND_W-1:0] cnt     [DEPTH];
    logic [PEND_W-1:0] cnt_nxt [DEPTH];
    logic [HIT_W-1:0]  hits    [DEPTH];
    logic [DEPTH-1:0]  under;
    logic [SUM_W-1:0]  sum;
    logic              iss_acc;
    logic [ADDR_W-1:0] ba;
    logic              busy_v;

    assign iss_ready = (rst != RST_ENABLE) && (cnt[iss_addr] != '1);
    assign iss_acc   = iss_valid && iss_ready;

    // Net update: one increment for an accepted issue minus every write port hitting the register.
    always_comb begin
        sum = '0;
        for (int r = 0; r < DEPTH; r++) begin
            hits[r]    = '0;
            cnt_nxt[r] = cnt[r];
            under[r]   = 1'b0;
        end
        for (int r = 1; r < DEPTH; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wb_we[w] == WRITE_ENABLE && wb_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    hits[r] = hits[r] + HIT_W'(1);
            end
            sum = SUM_W'(cnt[r]) + SUM_W'(iss_acc && (iss_addr == ADDR_W'(r)));
            if (sum < SUM_W'(hits[r])) begin
                cnt_nxt[r] = '0;
                under[r]   = 1'b1;
            end else begin
                cnt_nxt[r] = PEND_W'(sum - SUM_W'(hits[r]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
            if (|under) sb_err <= 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        ba      = '0;
        busy_v  = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ba = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            busy_v = SUM_W'(cnt[ba]) > SUM_W'(hits[ba]);
`else
            busy_v = cnt[ba] != '0;
`endif
            rd_busy[p] = (rst != RST_ENABLE) && (rd_re[p] == READ_ENABLE) && (ba != '0) && busy_v;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (r0 hardwired to zero) with a pending-write scoreboard for RAW stalls.
// REGFILE_BYPASS_EN: reads forward same-cycle write-back data (highest matching port).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wb_we,
    input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
    input  logic [NUM_WR*DATA_W-1:0] wb_data,
    input  logic [NUM_RD-1:0]        rd_re,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     sb_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    // Ports are applied in ascending order so the highest index wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wb_we[w] == WRITE_ENABLE && wb_addr[w*ADDR_W +: ADDR_W] != '0)
                    regs[wb_addr[w*ADDR_W +: ADDR_W]] <= wb_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wb_we[w] == WRITE_ENABLE && wb_addr[w*ADDR_W +: ADDR_W] == ra)
                    rv = wb_data[w*DATA_W +: DATA_W];
            end
`endif
            if (rst != RST_ENABLE && rd_re[p] == READ_ENABLE && ra != '0)
                rd_data[p*DATA_W +: DATA_W] = rv;
        end
    end

    regfile_mp_sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .rd_re     (rd_re),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .sb_err    (sb_err)
    );

endmodule
